// File: rtl/an_ordset_gen.sv
// Clause-37 auto-negotiation transmit ordered-set generator (byte-wide, pre-8b10b).
// Emits break-link, ability, acknowledge and idle sets, then pulses done and holds /I2/.
module an_ordset_gen #(
   parameter int unsigned SGMII_MODE   = 1,
   parameter int unsigned BREAK_SETS   = 4,
   parameter int unsigned ABILITY_SETS = 8,
   parameter int unsigned ACK_SETS     = 8,
   parameter int unsigned LINK_TIMER   = 64
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic [15:0] i_an_config,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_is_k,
   output logic        o_busy,
   output logic        o_done,
   output logic [2:0]  o_an_state
);

   localparam int unsigned MAX_BA = (BREAK_SETS > ABILITY_SETS) ? BREAK_SETS : ABILITY_SETS;
   localparam int unsigned MAX_KL = (ACK_SETS > LINK_TIMER) ? ACK_SETS : LINK_TIMER;
   localparam int unsigned MAX_P  = (MAX_BA > MAX_KL) ? MAX_BA : MAX_KL;
   localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] D21_5 = 8'hB5;
   localparam logic [7:0] D2_2  = 8'h42;
   localparam logic [7:0] D16_2 = 8'h50;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BREAK    = 3'd1,
      S_ABILITY  = 3'd2,
      S_ACK      = 3'd3,
      S_IDLE_DET = 3'd4,
      S_LINK_OK  = 3'd5
   } state_t;

   // Registers describe the byte currently on the output pins.
   state_t           r_state;
   logic [1:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_c2;
   logic             r_pend;
   logic [15:0]      r_cfg;
   logic [7:0]       r_tx_data;
   logic             r_tx_is_k;
   logic             r_busy;
   logic             r_done;

   state_t           w_state;
   logic [1:0]       w_idx;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_c2;
   logic             w_pend;
   logic [15:0]      w_cfg;
   logic [7:0]       w_tx_data;
   logic             w_tx_is_k;
   logic             w_busy;
   logic             w_done;
   logic             w_last;
   logic             w_restart;
   logic             w_enter;

   function automatic logic is_cfg(input state_t s);
      return (s == S_BREAK) || (s == S_ABILITY) || (s == S_ACK);
   endfunction

   // States with a zero set count are passed straight through.
   function automatic state_t skip_empty(input state_t s);
      state_t v;
      v = s;
      if (v == S_BREAK && BREAK_SETS == 0) v = S_ABILITY;
      if (v == S_ABILITY && ABILITY_SETS == 0) v = S_ACK;
      if (v == S_ACK && ACK_SETS == 0) v = S_IDLE_DET;
      return v;
   endfunction

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_idx     <= 2'd0;
         r_cnt     <= '0;
         r_c2      <= 1'b0;
         r_pend    <= 1'b0;
         r_cfg     <= 16'h0000;
         r_tx_data <= K28_5;
         r_tx_is_k <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_idx     <= w_idx;
         r_cnt     <= w_cnt;
         r_c2      <= w_c2;
         r_pend    <= w_pend;
         r_cfg     <= w_cfg;
         r_tx_data <= w_tx_data;
         r_tx_is_k <= w_tx_is_k;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end

   // Next position in the stream; state may only move on the last byte of a set.
   always_comb begin
      w_state   = r_state;
      w_idx     = r_idx + 2'd1;
      w_cnt     = r_cnt;
      w_cnt_inc = r_cnt + CNT_W'(1);
      w_c2      = r_c2;
      w_done    = 1'b0;
      w_enter   = 1'b0;
      w_restart = i_start | r_pend;
      w_pend    = w_restart;
      w_last    = is_cfg(r_state) ? (r_idx == 2'd3) : (r_idx == 2'd1);

      if (r_state == S_IDLE_DET) w_cnt = w_cnt_inc;

      if (w_last) begin
         w_idx  = 2'd0;
         w_c2   = ~r_c2;
         w_pend = 1'b0;
         if (w_restart) begin
            w_state = skip_empty(S_BREAK);
            w_enter = 1'b1;
         end else begin
            case (r_state)
               S_BREAK: begin
                  if (w_cnt_inc == CNT_W'(BREAK_SETS)) begin
                     w_state = skip_empty(S_ABILITY);
                     w_enter = 1'b1;
                  end else begin
                     w_cnt = w_cnt_inc;
                  end
               end
               S_ABILITY: begin
                  if (w_cnt_inc == CNT_W'(ABILITY_SETS)) begin
                     w_state = skip_empty(S_ACK);
                     w_enter = 1'b1;
                  end else begin
                     w_cnt = w_cnt_inc;
                  end
               end
               S_ACK: begin
                  if (w_cnt_inc == CNT_W'(ACK_SETS)) begin
                     w_state = S_IDLE_DET;
                     w_enter = 1'b1;
                  end else begin
                     w_cnt = w_cnt_inc;
                  end
               end
               S_IDLE_DET: begin
                  if (w_cnt_inc == CNT_W'(LINK_TIMER)) begin
                     w_state = S_LINK_OK;
                     w_enter = 1'b1;
                     w_done  = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (w_enter) begin
            w_cnt = '0;
            w_c2  = 1'b0;
         end
      end
   end

   // Byte selection for the next position; cfg is captured only at byte 0 of a config set.
   always_comb begin
      w_cfg     = r_cfg;
      w_tx_data = K28_5;
      w_tx_is_k = 1'b0;
      w_busy    = (w_state == S_BREAK) || (w_state == S_ABILITY) ||
                  (w_state == S_ACK)   || (w_state == S_IDLE_DET);

      if (w_idx == 2'd0 && is_cfg(w_state)) begin
         if (w_state == S_BREAK) begin
            w_cfg = 16'h0000;
         end else begin
            w_cfg = i_an_config;
            if (SGMII_MODE != 0) w_cfg[0] = 1'b1;
            w_cfg[14] = (w_state == S_ACK);
         end
      end

      case (w_idx)
         2'd0: begin
            w_tx_data = K28_5;
            w_tx_is_k = 1'b1;
         end
         2'd1:    w_tx_data = is_cfg(w_state) ? (w_c2 ? D2_2 : D21_5) : D16_2;
         2'd2:    w_tx_data = w_cfg[7:0];
         default: w_tx_data = w_cfg[15:8];
      endcase
   end

   assign o_tx_data  = r_tx_data;
   assign o_tx_is_k  = r_tx_is_k;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_an_state = r_state;

endmodule

// File: tb/tb_an_ordset_gen.sv
// Randomised bench for an_ordset_gen: two parameterisations run side by side against
// a set-level reference model that builds each expected ordered set whole.
module tb_an_ordset_gen;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] an_config;
   logic [7:0]  tx_data  [2];
   logic        tx_is_k  [2];
   logic        busy     [2];
   logic        done     [2];
   logic [2:0]  an_state [2];

   int n_chk;
   int n_err;
   int cyc;

   an_ordset_gen #(
      .SGMII_MODE(1), .BREAK_SETS(4), .ABILITY_SETS(8), .ACK_SETS(8), .LINK_TIMER(64)
   ) u_dut0 (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_an_config(an_config),
      .o_tx_data(tx_data[0]), .o_tx_is_k(tx_is_k[0]), .o_busy(busy[0]),
      .o_done(done[0]), .o_an_state(an_state[0])
   );

   an_ordset_gen #(
      .SGMII_MODE(0), .BREAK_SETS(0), .ABILITY_SETS(3), .ACK_SETS(1), .LINK_TIMER(6)
   ) u_dut1 (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_an_config(an_config),
      .o_tx_data(tx_data[1]), .o_tx_is_k(tx_is_k[1]), .o_busy(busy[1]),
      .o_done(done[1]), .o_an_state(an_state[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p_sg(input int d); return (d == 0) ? 1  : 0; endfunction
   function automatic int p_bs(input int d); return (d == 0) ? 4  : 0; endfunction
   function automatic int p_as(input int d); return (d == 0) ? 8  : 3; endfunction
   function automatic int p_ks(input int d); return (d == 0) ? 8  : 1; endfunction
   function automatic int p_lt(input int d); return (d == 0) ? 64 : 6; endfunction

   // Reference model: phase, sets/cycles left, and the whole ordered set being sent.
   int         m_phase [2];
   int         m_left  [2];
   int         m_pos   [2];
   int         m_len   [2];
   bit         m_c2    [2];
   bit         m_pend  [2];
   bit         m_done1 [2];
   logic [7:0] m_byte  [2][4];
   bit         m_k     [2][4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int d);
      m_phase[d] = 0;
      m_left[d]  = 0;
      m_c2[d]    = 1'b0;
      m_pend[d]  = 1'b0;
      m_done1[d] = 1'b0;
      m_byte[d][0] = 8'hBC; m_k[d][0] = 1'b1;
      m_byte[d][1] = 8'h50; m_k[d][1] = 1'b0;
      m_len[d] = 2;
      m_pos[d] = 0;
   endtask

   task automatic gen_set(input int d, input logic [15:0] cfg);
      bit          dn;
      logic [15:0] v;
      dn = 1'b0;
      if (m_pend[d]) begin
         m_phase[d] = 1;
         m_left[d]  = p_bs(d);
         m_c2[d]    = 1'b0;
         m_pend[d]  = 1'b0;
      end
      while (m_phase[d] >= 1 && m_phase[d] <= 3 && m_left[d] == 0) begin
         m_phase[d] = m_phase[d] + 1;
         m_c2[d]    = 1'b0;
         m_left[d]  = (m_phase[d] == 2) ? p_as(d) : (m_phase[d] == 3) ? p_ks(d) : p_lt(d);
      end
      if (m_phase[d] == 4 && m_left[d] == 0) begin
         m_phase[d] = 5;
         dn = 1'b1;
      end
      m_byte[d][0] = 8'hBC;
      m_k[d][0] = 1'b1; m_k[d][1] = 1'b0; m_k[d][2] = 1'b0; m_k[d][3] = 1'b0;
      if (m_phase[d] >= 1 && m_phase[d] <= 3) begin
         if (m_phase[d] == 1) begin
            v = 16'h0000;
         end else begin
            v = cfg;
            if (p_sg(d) != 0) v[0] = 1'b1;
            v[14] = (m_phase[d] == 3);
         end
         m_byte[d][1] = m_c2[d] ? 8'h42 : 8'hB5;
         m_byte[d][2] = v[7:0];
         m_byte[d][3] = v[15:8];
         m_len[d]  = 4;
         m_c2[d]   = ~m_c2[d];
         m_left[d] = m_left[d] - 1;
      end else begin
         m_byte[d][1] = 8'h50;
         m_len[d] = 2;
         if (m_phase[d] == 4) m_left[d] = m_left[d] - 2;
      end
      m_pos[d]   = 0;
      m_done1[d] = dn;
   endtask

   task automatic model_step(input int d, input bit s, input logic [15:0] cfg);
      m_pend[d] = m_pend[d] | s;
      m_pos[d]  = m_pos[d] + 1;
      if (m_pos[d] >= m_len[d]) gen_set(d, cfg);
   endtask

   function automatic logic [13:0] m_exp(input int d);
      logic b;
      b = (m_phase[d] >= 1 && m_phase[d] <= 4);
      return {3'(m_phase[d]), (m_done1[d] && m_pos[d] == 0), b,
              m_k[d][m_pos[d]], m_byte[d][m_pos[d]]};
   endfunction

   function automatic logic [13:0] dut_obs(input int d);
      return {an_state[d], done[d], busy[d], tx_is_k[d], tx_data[d]};
   endfunction

   // Called at a negedge: drive inputs, advance the model across the next posedge, check.
   task automatic cycle(input bit s, input logic [15:0] cfg);
      start     = s;
      an_config = cfg;
      for (int d = 0; d < 2; d++) model_step(d, s, cfg);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      for (int d = 0; d < 2; d++)
         check($sformatf("d%0d_cyc%0d", d, cyc), 32'(dut_obs(d)), 32'(m_exp(d)));
   endtask

   // Async reset asserted between edges; outputs must drop without waiting for a clock.
   task automatic async_reset();
      start = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         check($sformatf("async_rst_d%0d", d), 32'(dut_obs(d)), 32'(m_exp(d)));
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         check($sformatf("rst_hold_d%0d", d), 32'(dut_obs(d)), 32'(m_exp(d)));
      rst_n = 1'b1;
   endtask

   initial begin
      int t0, t1, ndone, hit_abil, hit_fin;
      bit found;
      n_chk = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0; start = 1'b0; an_config = 16'h01A0;
      for (int d = 0; d < 2; d++) model_reset(d);
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++)
         check($sformatf("reset_d%0d", d), 32'(dut_obs(d)), 32'(m_exp(d)));
      rst_n = 1'b1;

      // Idle stream with no start
      for (int i = 0; i < 20; i++) cycle(1'b0, 16'h01A0);

      // One full negotiation at default config
      t0 = -1; t1 = -1; ndone = 0;
      for (int i = 0; i < 240; i++) begin
         cycle(i == 1, 16'h01A0);
         if (busy[0] && t0 < 0) t0 = cyc;
         if (done[0]) begin
            ndone++;
            if (t1 < 0) t1 = cyc;
         end
      end
      check("done_latency", 32'(t1 - t0), 32'd144);
      check("done_count", 32'(ndone), 32'd1);

      // Restart from LINK_OK with a different advertised word
      for (int i = 0; i < 100; i++) cycle(i == 0, 16'h0020);

      // Random traffic with targeted restarts and occasional async resets
      hit_abil = 0; hit_fin = 0;
      for (int i = 0; i < 5000; i++) begin
         bit s, fin;
         s   = ($urandom_range(0, 299) == 0);
         fin = 1'b0;
         if (m_phase[0] == 2 && m_pos[0] == 2 && $urandom_range(0, 15) == 0) begin
            s = 1'b1;
            hit_abil++;
         end
         if (m_phase[0] == 4 && m_left[0] == 0 && m_pos[0] == 1 && $urandom_range(0, 1) == 0) begin
            s   = 1'b1;
            fin = 1'b1;
            hit_fin++;
         end
         cycle(s, 16'($urandom));
         if (fin) begin
            check("fin_restart_no_done", 32'(done[0]), 32'd0);
            check("fin_restart_state", 32'(an_state[0]), 32'd1);
         end
         if ($urandom_range(0, 1999) == 0) async_reset();
      end
      check("hit_ability_restart", 32'(hit_abil != 0), 32'd1);
      check("hit_final_restart", 32'(hit_fin != 0), 32'd1);

      // Async reset while byte 1 of a /C2/ is on the wire
      found = 1'b0;
      cycle(1'b1, 16'h1234);
      for (int i = 0; i < 100 && !found; i++) begin
         if (m_phase[0] >= 1 && m_phase[0] <= 3 && m_pos[0] == 1 && m_byte[0][1] == 8'h42) begin
            async_reset();
            found = 1'b1;
         end else begin
            cycle(1'b0, 16'h1234);
         end
      end
      check("c2_reset_reached", 32'(found), 32'd1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 16'h1234);
      check("busy_after_reset", 32'(busy[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
